// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy obstacle field: run-state encoding,
// LFSR polynomial/seed and the VGA coordinate that marks a new frame.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam logic [9:0] VGA_ORIGIN_H = 10'd0;
    localparam logic [9:0] VGA_ORIGIN_V = 10'd0;

    // One right-shift step of a Galois LFSR; a non-zero state never reaches zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/wall_field_scroller_if.sv
// Bundle of the frame/control inputs and the column outputs of the scroller.
interface wall_field_scroller_if #(
    parameter int NUM_WALLS = 2,
    parameter int COORD_W   = 11,
    parameter int SCORE_W   = 8
);
    logic [9:0]                   h_counter;
    logic [9:0]                   v_counter;
    logic                         start;
    logic                         collide;
    logic [NUM_WALLS*COORD_W-1:0] wall_x;
    logic [NUM_WALLS*COORD_W-1:0] gap_top;
    logic [NUM_WALLS*COORD_W-1:0] gap_bot;
    logic [SCORE_W-1:0]           score;
    logic [4:0]                   speed;
    logic                         scored;
    logic [1:0]                   state;

    modport master (
        output h_counter, v_counter, start, collide,
        input  wall_x, gap_top, gap_bot, score, speed, scored, state
    );

    modport slave (
        input  h_counter, v_counter, start, collide,
        output wall_x, gap_top, gap_bot, score, speed, scored, state
    );
endinterface

// File: rtl/wall_lfsr.sv
// Free-running 16-bit Galois LFSR used to pick gap heights on respawn.
module wall_lfsr
    import flappy_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Advance one step every clock, whatever the game state.
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    // State register, seeded on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;
endmodule

// File: rtl/wall_field_scroller.sv
// Obstacle field: NUM_WALLS columns scrolling left once per divided frame,
// respawning with random gaps, scoring columns that pass the player and
// speeding up as the score grows. Start/collide drive IDLE/RUN/HALT.
module wall_field_scroller
    import flappy_pkg::*;
#(
    parameter int NUM_WALLS      = 2,
    parameter int COORD_W        = 11,
    parameter int SCREEN_W       = 800,
    parameter int WALL_W         = 40,
    parameter int SPACING        = 420,
    parameter int GAP_H          = 170,
    parameter int GAP_MIN_Y      = 100,
    parameter int GAP_RANGE_LOG2 = 7,
    parameter int FRAME_DIV      = 7,
    parameter int PLAYER_X       = 450,
    parameter int SPEED_INIT     = 5,
    parameter int SPEED_STEP     = 1,
    parameter int SPEED_MAX      = 15,
    parameter int SPEEDUP_LOG2   = 2,
    parameter int SCORE_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    wall_field_scroller_if.slave bus
);
    localparam int DIV_W     = (FRAME_DIV > 0) ? $clog2(FRAME_DIV + 1) : 1;
    localparam int SUM_W     = SCORE_W + 3;
    localparam int SCORE_MAX = (2 ** SCORE_W) - 1;

    if (SCREEN_W + (NUM_WALLS - 1) * SPACING >= 2 ** COORD_W) begin : g_chk_x
        $error("wall_field_scroller: initial wall positions exceed COORD_W");
    end
    if (GAP_MIN_Y + 2 ** GAP_RANGE_LOG2 + GAP_H >= 2 ** COORD_W) begin : g_chk_gap
        $error("wall_field_scroller: gap range exceeds COORD_W");
    end
    if (SPEED_MAX >= WALL_W) begin : g_chk_speed
        $error("wall_field_scroller: SPEED_MAX must be below WALL_W");
    end
    if (GAP_RANGE_LOG2 > 16) begin : g_chk_range
        $error("wall_field_scroller: GAP_RANGE_LOG2 exceeds LFSR width");
    end

    state_e               state_q, state_d;
    logic                 origin_q, origin_d;
    logic                 start_q, start_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [COORD_W-1:0]   wall_x_q [NUM_WALLS];
    logic [COORD_W-1:0]   wall_x_d [NUM_WALLS];
    logic [COORD_W-1:0]   gap_top_q [NUM_WALLS];
    logic [COORD_W-1:0]   gap_top_d [NUM_WALLS];
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [4:0]           speed_q, speed_d;
    logic                 scored_q, scored_d;

    logic [15:0]          lfsr;
    logic                 at_origin, frame_tick, start_rise, move;
    logic [COORD_W-1:0]   speed_ext;
    logic [NUM_WALLS-1:0] respawn, passes;
    logic [COORD_W-1:0]   moved_x [NUM_WALLS];
    logic [COORD_W-1:0]   spawn_gap [NUM_WALLS];
    logic [2:0]           pass_cnt;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;
    logic [5:0]           speed_sum;
    logic [4:0]           speed_sat;
    logic                 speed_up;

    wall_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign at_origin  = (bus.h_counter == VGA_ORIGIN_H) && (bus.v_counter == VGA_ORIGIN_V);
    assign frame_tick = at_origin && !origin_q;
    assign start_rise = bus.start && !start_q;
    assign speed_ext  = COORD_W'(speed_q);

    // Per-column candidate values for a move step; the gap draws a different
    // LFSR window per column, wrapping around the 16-bit register.
    for (genvar gi = 0; gi < NUM_WALLS; gi++) begin : g_wall
        localparam int OFF = (gi * GAP_RANGE_LOG2) % 16;
        logic [31:0]      lfsr_dbl;
        logic [COORD_W:0] old_edge;
        logic [COORD_W:0] new_edge;

        assign lfsr_dbl       = {lfsr, lfsr};
        assign respawn[gi]    = (wall_x_q[gi] <= speed_ext);
        assign moved_x[gi]    = wall_x_q[gi] - speed_ext;
        assign spawn_gap[gi]  = COORD_W'(GAP_MIN_Y) + COORD_W'(lfsr_dbl[OFF +: GAP_RANGE_LOG2]);
        assign old_edge       = {1'b0, wall_x_q[gi]} + (COORD_W + 1)'(WALL_W);
        assign new_edge       = {1'b0, moved_x[gi]} + (COORD_W + 1)'(WALL_W);
        assign passes[gi]     = !respawn[gi]
                              && (old_edge > (COORD_W + 1)'(PLAYER_X))
                              && (new_edge <= (COORD_W + 1)'(PLAYER_X));
    end

    // Flatten column registers onto the output buses.
    always_comb begin
        bus.wall_x  = '0;
        bus.gap_top = '0;
        bus.gap_bot = '0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            bus.wall_x[i*COORD_W +: COORD_W]  = wall_x_q[i];
            bus.gap_top[i*COORD_W +: COORD_W] = gap_top_q[i];
            bus.gap_bot[i*COORD_W +: COORD_W] = gap_top_q[i] + COORD_W'(GAP_H);
        end
    end

    assign bus.score  = score_q;
    assign bus.speed  = speed_q;
    assign bus.scored = scored_q;
    assign bus.state  = state_q;

    // Score and speed that a move step would produce: passes are summed,
    // the score saturates, and speed bumps once when the upper score bits rise.
    always_comb begin
        pass_cnt = '0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            pass_cnt = pass_cnt + 3'(passes[i]);
        end
        score_sum = SUM_W'(score_q) + SUM_W'(pass_cnt);
        score_sat = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];
        speed_up  = (score_sat >> SPEEDUP_LOG2) > (score_q >> SPEEDUP_LOG2);
        speed_sum = 6'(speed_q) + 6'(SPEED_STEP);
        speed_sat = (speed_sum > 6'(SPEED_MAX)) ? 5'(SPEED_MAX) : speed_sum[4:0];
    end

    // Run-state machine, frame divider and move-step application.
    always_comb begin
        state_d   = state_q;
        origin_d  = at_origin;
        start_d   = bus.start;
        div_d     = div_q;
        wall_x_d  = wall_x_q;
        gap_top_d = gap_top_q;
        score_d   = score_q;
        speed_d   = speed_q;
        scored_d  = 1'b0;
        move      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end
            end
            ST_RUN: begin
                if (bus.collide) begin
                    state_d = ST_HALT;
                end else if (frame_tick) begin
                    if (div_q == DIV_W'(FRAME_DIV)) begin
                        div_d = '0;
                        move  = 1'b1;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (start_rise) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    score_d = '0;
                    speed_d = 5'(SPEED_INIT);
                    for (int i = 0; i < NUM_WALLS; i++) begin
                        wall_x_d[i]  = COORD_W'(SCREEN_W + i * SPACING);
                        gap_top_d[i] = COORD_W'(GAP_MIN_Y);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (move) begin
            for (int i = 0; i < NUM_WALLS; i++) begin
                if (respawn[i]) begin
                    wall_x_d[i]  = COORD_W'(SCREEN_W);
                    gap_top_d[i] = spawn_gap[i];
                end else begin
                    wall_x_d[i]  = moved_x[i];
                end
            end
            score_d  = score_sat;
            scored_d = (pass_cnt != 3'd0);
            if (speed_up) begin
                speed_d = speed_sat;
            end
        end
    end

    // State registers; reset restores the initial field immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            origin_q <= 1'b0;
            start_q  <= 1'b0;
            div_q    <= '0;
            score_q  <= '0;
            speed_q  <= 5'(SPEED_INIT);
            scored_q <= 1'b0;
            for (int i = 0; i < NUM_WALLS; i++) begin
                wall_x_q[i]  <= COORD_W'(SCREEN_W + i * SPACING);
                gap_top_q[i] <= COORD_W'(GAP_MIN_Y);
            end
        end else begin
            state_q   <= state_d;
            origin_q  <= origin_d;
            start_q   <= start_d;
            div_q     <= div_d;
            score_q   <= score_d;
            speed_q   <= speed_d;
            scored_q  <= scored_d;
            wall_x_q  <= wall_x_d;
            gap_top_q <= gap_top_d;
        end
    end

endmodule
